// File: rtl/erase_car_if.sv
// ============================================================================
// Module : erase_car_if
// Desc   : Request, map-read and VGA-plot signals of the car eraser.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface erase_car_if;
  logic        start;
  logic [7:0]  iX;
  logic [6:0]  iY;
  logic [2:0]  iDir;
  logic [14:0] mem_addr;
  logic        mem_re;
  logic [8:0]  mem_rdata;
  logic [7:0]  oX;
  logic [6:0]  oY;
  logic [8:0]  oColour;
  logic        oPlot;
  logic        oBusy;
  logic        oDone;

  modport slave (
    input  start, iX, iY, iDir, mem_rdata,
    output mem_addr, mem_re, oX, oY, oColour, oPlot, oBusy, oDone
  );

  modport master (
    output start, iX, iY, iDir, mem_rdata,
    input  mem_addr, mem_re, oX, oY, oColour, oPlot, oBusy, oDone
  );
endinterface

`default_nettype wire

// File: rtl/erase_car.sv
// ============================================================================
// Module : erase_car
// Desc   : Replots map background over a car's bounding box (one pixel/cycle).
//          ERASE_DEBUG_FILL_EN: suppress map reads, plot DEBUG_COLOUR instead.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module erase_car #(
  parameter int         MEM_LATENCY  = 2,
  parameter int         SCREEN_W     = 160,
  parameter int         SCREEN_H     = 120,
  parameter logic [8:0] DEBUG_COLOUR = 9'h1C7
) (
  input  logic       clk,
  input  logic       resetn,
  erase_car_if.slave bus
);

  localparam logic [2:0] c_S_IDLE  = 3'd0;
  localparam logic [2:0] c_S_LOAD  = 3'd1;
  localparam logic [2:0] c_S_SCAN  = 3'd2;
  localparam logic [2:0] c_S_DRAIN = 3'd3;
  localparam logic [2:0] c_S_DONE  = 3'd4;

  logic [2:0]  r_state;
  logic [7:0]  r_rx;
  logic [6:0]  r_ry;
  logic [2:0]  r_rdir;
  logic [3:0]  r_cx;
  logic [3:0]  r_cy;
  logic [2:0]  r_drain;
  logic        r_mem_re;
  logic [14:0] r_mem_addr;
  logic [15:0] r_pipe [0:MEM_LATENCY];
  logic [7:0]  r_hold_x;
  logic [6:0]  r_hold_y;
  logic [8:0]  r_hold_colour;
  logic        r_busy;
  logic        r_done;

  logic [3:0]  w_w;
  logic [3:0]  w_h;
  logic [8:0]  w_px;
  logic [7:0]  w_py;
  logic        w_in;
  logic [14:0] w_addr;
  logic [15:0] w_out;
  logic [8:0]  w_colour;

  // Horizontal (0/4), vertical (2/6) or diagonal (odd) sprite footprint
  always_comb begin
    w_w = 4'd15;
    w_h = 4'd15;
    if (!r_rdir[0]) begin
      if (r_rdir[1]) begin
        w_w = 4'd8;
        w_h = 4'd14;
      end else begin
        w_w = 4'd14;
        w_h = 4'd8;
      end
    end
  end

  // Widened sums so a box hanging off the right/bottom edge is clipped, not wrapped
  assign w_px   = {1'b0, r_rx} + {5'd0, r_cx};
  assign w_py   = {1'b0, r_ry} + {4'd0, r_cy};
  assign w_in   = (r_state == c_S_SCAN) && (w_px < 9'(SCREEN_W)) && (w_py < 8'(SCREEN_H));
  assign w_addr = 15'(w_px) + 15'(w_py) * 15'(SCREEN_W);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= c_S_IDLE;
      r_rx    <= '0;
      r_ry    <= '0;
      r_rdir  <= '0;
      r_cx    <= '0;
      r_cy    <= '0;
      r_drain <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_busy <= (r_state != c_S_IDLE) && (r_state != c_S_DONE);
      r_done <= (r_state == c_S_DONE);
      case (r_state)
        c_S_IDLE: begin
          if (bus.start) r_state <= c_S_LOAD;
        end
        c_S_LOAD: begin
          r_rx    <= bus.iX;
          r_ry    <= bus.iY;
          r_rdir  <= bus.iDir;
          r_cx    <= '0;
          r_cy    <= '0;
          r_state <= c_S_SCAN;
        end
        c_S_SCAN: begin
          if (r_cx == w_w - 4'd1) begin
            r_cx <= '0;
            if (r_cy == w_h - 4'd1) begin
              r_drain <= '0;
              r_state <= c_S_DRAIN;
            end else begin
              r_cy <= r_cy + 4'd1;
            end
          end else begin
            r_cx <= r_cx + 4'd1;
          end
        end
        c_S_DRAIN: begin
          if (r_drain == 3'(MEM_LATENCY - 1)) r_state <= c_S_DONE;
          else r_drain <= r_drain + 3'd1;
        end
        c_S_DONE: r_state <= c_S_IDLE;
        default:  r_state <= c_S_IDLE;
      endcase
    end
  end

  // Stage 0 issues the read; stage MEM_LATENCY meets the returned colour
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_mem_re      <= 1'b0;
      r_mem_addr    <= '0;
      r_hold_x      <= '0;
      r_hold_y      <= '0;
      r_hold_colour <= '0;
      for (int k = 0; k <= MEM_LATENCY; k++) r_pipe[k] <= '0;
    end else begin
`ifdef ERASE_DEBUG_FILL_EN
      r_mem_re <= 1'b0;
`else
      r_mem_re <= w_in;
`endif
      if (w_in) r_mem_addr <= w_addr;
      r_pipe[0] <= {w_px[7:0], w_py[6:0], w_in};
      for (int k = 1; k <= MEM_LATENCY; k++) r_pipe[k] <= r_pipe[k-1];
      if (w_out[0]) begin
        r_hold_x      <= w_out[15:8];
        r_hold_y      <= w_out[7:1];
        r_hold_colour <= w_colour;
      end
    end
  end

  assign w_out = r_pipe[MEM_LATENCY];

`ifdef ERASE_DEBUG_FILL_EN
  assign w_colour = DEBUG_COLOUR;
`else
  assign w_colour = bus.mem_rdata;
`endif

  assign bus.mem_re   = r_mem_re;
  assign bus.mem_addr = r_mem_addr;
  assign bus.oPlot    = w_out[0];
  assign bus.oX       = w_out[0] ? w_out[15:8] : r_hold_x;
  assign bus.oY       = w_out[0] ? w_out[7:1]  : r_hold_y;
  assign bus.oColour  = w_out[0] ? w_colour    : r_hold_colour;
  assign bus.oBusy    = r_busy;
  assign bus.oDone    = r_done;

endmodule

`default_nettype wire

// File: tb/tb_erase_car.sv
// ============================================================================
// Module : tb_erase_car
// Desc   : Self-checking bench for erase_car against a box-walk reference model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_erase_car;
  localparam int L = 2;

  typedef struct {int cyc; int addr;} re_t;
  typedef struct {int cyc; int x; int y; int col;} plot_t;
  typedef struct {
    int x; int y; int dir; int n_re; int n_pl;
    int first; int last; int lx; int ly; int done_off;
  } vec_t;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  erase_car_if bus ();
  erase_car #(.MEM_LATENCY(L)) dut (.clk(clk), .resetn(resetn), .bus(bus));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Map memory: returns addr[8:0] exactly L cycles after the address is presented
  logic [14:0] hist [L];
  always @(posedge clk) begin
    hist[0] <= bus.mem_addr;
    for (int k = 1; k < L; k++) hist[k] <= hist[k-1];
  end
  assign bus.mem_rdata = hist[L-1][8:0];

  re_t   act_re[$], exp_re[$];
  plot_t act_pl[$], exp_pl[$];
  int    act_done[$];
  int    exp_done, t0, busy_err;
  bit    run_on = 1'b0;
  int    n_chk = 0, n_pass = 0;

  always @(negedge clk) begin
    re_t e;
    plot_t p;
    if (bus.mem_re) begin
      e.cyc = cyc; e.addr = int'(bus.mem_addr);
      act_re.push_back(e);
    end
    if (bus.oPlot) begin
      p.cyc = cyc; p.x = int'(bus.oX); p.y = int'(bus.oY); p.col = int'(bus.oColour);
      act_pl.push_back(p);
    end
    if (bus.oDone) act_done.push_back(cyc);
    if (run_on && (bus.oBusy !== ((cyc > t0) && (cyc < exp_done)))) busy_err++;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int req);
    n_chk++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, req);
  endtask

  // Reference: walk the box row-major; pixel i is read at t0+2+i and plotted L later
  task automatic model(input int x, input int y, input int dir);
    int w, h, px, py, i;
    re_t e;
    plot_t p;
    exp_re.delete(); exp_pl.delete();
    act_re.delete(); act_pl.delete(); act_done.delete();
    busy_err = 0;
    if (dir % 2 == 1) begin w = 15; h = 15; end
    else if (dir % 4 == 0) begin w = 14; h = 8; end
    else begin w = 8; h = 14; end
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        i = r * w + c; px = x + c; py = y + r;
        if (px < 160 && py < 120) begin
          e.cyc = t0 + 2 + i; e.addr = px + 160 * py;
`ifndef ERASE_DEBUG_FILL_EN
          exp_re.push_back(e);
`endif
          p.cyc = t0 + 2 + i + L; p.x = px; p.y = py;
`ifdef ERASE_DEBUG_FILL_EN
          p.col = 'h1C7;
`else
          p.col = e.addr % 512;
`endif
          exp_pl.push_back(p);
        end
      end
    end
    exp_done = t0 + w * h + L + 2;
  endtask

  task automatic start_run(input int x, input int y, input int dir);
    bus.start = 1'b1;
    bus.iX = 8'(x); bus.iY = 7'(y); bus.iDir = 3'(dir);
    t0 = cyc + 1;
    model(x, y, dir);
    run_on = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    bus.iX = 8'($urandom); bus.iY = 7'($urandom); bus.iDir = 3'($urandom);
  endtask

  task automatic finish_run(input string tag, input int extra);
    int budget, bad;
    budget = 0;
    while (act_done.size() == 0 && budget < 600) begin
      tick();
      budget++;
    end
    repeat (extra) tick();
    run_on = 1'b0;
    chk({tag, " done_count"}, act_done.size(), 1);
    chk({tag, " done_cycle"}, act_done.size() > 0 ? act_done[0] : -1, exp_done);
    chk({tag, " re_count"}, act_re.size(), exp_re.size());
    bad = 0;
    for (int i = 0; i < act_re.size() && i < exp_re.size(); i++)
      if (act_re[i] != exp_re[i]) bad++;
    chk({tag, " re_seq_errors"}, bad, 0);
    chk({tag, " plot_count"}, act_pl.size(), exp_pl.size());
    bad = 0;
    for (int i = 0; i < act_pl.size() && i < exp_pl.size(); i++)
      if (act_pl[i] != exp_pl[i]) bad++;
    chk({tag, " plot_seq_errors"}, bad, 0);
    chk({tag, " busy_errors"}, busy_err, 0);
  endtask

  vec_t vt [3];

  initial begin
    vt[0] = '{10, 20, 0, 112, 112, 3210, 4343, 23, 27, 116};
    vt[1] = '{0, 0, 6, 112, 112, 0, 2087, 7, 13, 116};
    vt[2] = '{150, 110, 3, 100, 100, 17750, 19199, 159, 119, 229};

    bus.start = 1'b0; bus.iX = '0; bus.iY = '0; bus.iDir = '0;
    resetn = 1'b0;
    repeat (3) tick();
    chk("rst mem_re", int'(bus.mem_re), 0);
    chk("rst mem_addr", int'(bus.mem_addr), 0);
    chk("rst oPlot", int'(bus.oPlot), 0);
    chk("rst oX", int'(bus.oX), 0);
    chk("rst oY", int'(bus.oY), 0);
    chk("rst oColour", int'(bus.oColour), 0);
    chk("rst oBusy", int'(bus.oBusy), 0);
    chk("rst oDone", int'(bus.oDone), 0);
    resetn = 1'b1;
    tick();

    for (int i = 0; i < 3; i++) begin
      start_run(vt[i].x, vt[i].y, vt[i].dir);
      finish_run($sformatf("vec%0d", i), 4);
      chk($sformatf("vec%0d n_plot", i), act_pl.size(), vt[i].n_pl);
      chk($sformatf("vec%0d done_off", i), act_done.size() > 0 ? act_done[0] - t0 : -1, vt[i].done_off);
      chk($sformatf("vec%0d last_x", i), act_pl.size() > 0 ? act_pl[act_pl.size()-1].x : -1, vt[i].lx);
      chk($sformatf("vec%0d last_y", i), act_pl.size() > 0 ? act_pl[act_pl.size()-1].y : -1, vt[i].ly);
`ifndef ERASE_DEBUG_FILL_EN
      chk($sformatf("vec%0d n_re", i), act_re.size(), vt[i].n_re);
      chk($sformatf("vec%0d first_addr", i), act_re.size() > 0 ? act_re[0].addr : -1, vt[i].first);
      chk($sformatf("vec%0d last_addr", i), act_re.size() > 0 ? act_re[act_re.size()-1].addr : -1, vt[i].last);
`else
      chk($sformatf("vec%0d n_re", i), act_re.size(), 0);
`endif
    end

    repeat (6) begin
      start_run(int'($urandom_range(0, 159)), int'($urandom_range(0, 119)), int'($urandom_range(0, 7)));
      finish_run("rand", 4);
    end

    // Second start mid-scan must be ignored
    start_run(10, 20, 0);
    repeat (30) tick();
    bus.start = 1'b1; bus.iX = 8'd50; bus.iY = 7'd5; bus.iDir = 3'd3;
    tick();
    bus.start = 1'b0;
    finish_run("repulse", 6);

    // Reset during the 50th scan cycle
    start_run(10, 20, 0);
    while (cyc < t0 + 50) tick();
    resetn = 1'b0;
    tick();
    chk("abort mem_re", int'(bus.mem_re), 0);
    chk("abort oPlot", int'(bus.oPlot), 0);
    chk("abort oBusy", int'(bus.oBusy), 0);
    chk("abort oDone", int'(bus.oDone), 0);
    resetn = 1'b1;
    run_on = 1'b0;
    act_re.delete(); act_pl.delete(); act_done.delete();
    repeat (10) tick();
    chk("abort stray_re", act_re.size(), 0);
    chk("abort stray_plot", act_pl.size(), 0);
    chk("abort stray_done", act_done.size(), 0);
    start_run(30, 40, 5);
    finish_run("after_abort", 4);

    // Back-to-back: restart in the cycle right after oDone
    start_run(0, 0, 2);
    finish_run("b2b_a", 0);
    tick();
    start_run(140, 100, 1);
    finish_run("b2b_b", 4);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

`default_nettype wire
